// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage: instruction codes, status
// codes and the memory-access FSM state type.
package y86_pkg;

  // Instruction codes that touch data memory (plus NOP for idle slots)
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Pipeline status codes
  localparam logic [1:0] S_AOK = 2'b00;
  localparam logic [1:0] S_HLT = 2'b01;
  localparam logic [1:0] S_ADR = 2'b10;
  localparam logic [1:0] S_INS = 2'b11;

  // Memory-access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Byte-addressed data memory with an 8-byte little-endian combinational read
// port and an 8-byte synchronous write port. The caller guarantees that
// addr..addr+7 lies inside the array whenever the data is used.
module data_mem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  // NOTE: storage arrays get no reset; reset only clears control state.
  logic [7:0] r_mem [MEM_BYTES];

  // Assemble 8 bytes little-endian: byte at addr lands in rdata[7:0]
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = r_mem[addr + AW'(k)];
    end
  end

  // Commit all 8 bytes on the clock edge when a write is enabled
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[addr + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 pipeline memory stage: op decode, address check, access-latency
// sequencer and output muxing around data_mem. A valid access stalls the
// pipeline for exactly LATENCY cycles; the cycle after the last stall is the
// completion cycle in which read data appears and a write is committed.
// Optional build macro: MEM_ALIGN_CHECK_EN (faults addresses not 8-byte aligned).
module mem_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat,
  output logic        mem_stall
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
  // The IDLE cycle is the first stall cycle, so WAIT lasts LATENCY-1 cycles
  // and the counter holds the number of WAIT cycles still to go after this one.
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic        w_is_read;
  logic        w_is_write;
  logic [63:0] w_addr;
  logic        w_misalign;
  logic        w_req;
  logic        w_fault;
  logic        w_access;
  logic        w_complete;
  logic        w_we;
  logic [63:0] w_rdata;
  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_stall;

  // Classify the op and pick its address source
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_is_read  = 1'b0;
    w_is_write = 1'b0;
    w_addr     = M_valE;
    case (M_icode)
      I_MRMOVQ:                  w_is_read  = 1'b1;
      I_RET, I_POPQ:   begin     w_is_read  = 1'b1; w_addr = M_valA; end
      I_RMMOVQ, I_CALL, I_PUSHQ: w_is_write = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (w_addr[2:0] != 3'b000);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req    = (M_stat == S_AOK) && (w_is_read || w_is_write);
  assign w_fault  = w_req && ((w_addr > ADDR_MAX) || w_misalign);
  assign w_access = w_req && !w_fault;

  // Sequencer next-state, counter and stall request
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access && (LATENCY != 0)) begin
          w_stall     = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and counter registers; reset returns to IDLE from any state
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Completion happens immediately at zero latency, otherwise in DONE
  assign w_complete = !reset && w_access &&
                      (((r_state == ST_IDLE) && (LATENCY == 0)) || (r_state == ST_DONE));
  assign w_we       = w_complete && w_is_write;

  data_mem #(.MEM_BYTES(MEM_BYTES), .AW(AW)) u_data_mem (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_addr[AW-1:0]),
    .wdata (M_valA),
    .rdata (w_rdata)
  );

  assign m_valM    = (w_complete && w_is_read) ? w_rdata : 64'd0;
  assign m_stat    = reset ? S_AOK : (w_fault ? S_ADR : M_stat);
  assign mem_stall = !reset && w_stall;

endmodule
